// File: rtl/spatz_offload_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spatz_offload_ctrl
// Description : Buffers core offload requests in a small FIFO, issues them to
//               the vector unit and returns scalar/illegal responses.
// Revision    : 1.0 - initial release
// ============================================================================
module spatz_offload_ctrl #(
    parameter int unsigned FifoDepth = 2,
    parameter int unsigned StatWidth = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 core_valid_i,
    output logic                 core_ready_o,
    input  logic [31:0]          core_instr_i,
    input  logic [31:0]          core_rs1_i,
    input  logic [31:0]          core_rs2_i,
    input  logic [4:0]           core_rd_i,
    input  logic                 core_wb_i,

    output logic                 acc_valid_o,
    output logic [31:0]          acc_instr_o,
    output logic [31:0]          acc_rs1_o,
    output logic [31:0]          acc_rs2_o,
    input  logic                 acc_illegal_i,
    input  logic [31:0]          acc_rd_i,

    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_data_o,
    output logic [4:0]           rsp_rd_o,
    output logic                 rsp_illegal_o,

    output logic                 busy_o,
    output logic [StatWidth-1:0] illegal_cnt_o
);

    localparam int unsigned c_ADDR_W = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam logic [c_ADDR_W:0]    c_PTR_ONE = 1;
    localparam logic [StatWidth-1:0] c_CNT_ONE = 1;

    typedef enum logic [0:0] {
        ST_ISSUE = 1'b0,
        ST_RESP  = 1'b1
    } state_e;

    state_e r_state;

    logic [31:0] r_mem_instr [FifoDepth];
    logic [31:0] r_mem_rs1   [FifoDepth];
    logic [31:0] r_mem_rs2   [FifoDepth];
    logic [4:0]  r_mem_rd    [FifoDepth];
    logic        r_mem_wb    [FifoDepth];

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [c_ADDR_W:0] r_wr_ptr;
    logic [c_ADDR_W:0] r_rd_ptr;

    logic                 r_rsp_valid;
    logic [31:0]          r_rsp_data;
    logic [4:0]           r_rsp_rd;
    logic                 r_rsp_illegal;
    logic [StatWidth-1:0] r_illegal_cnt;

    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [c_ADDR_W-1:0] w_wr_idx;
    logic [c_ADDR_W-1:0] w_rd_idx;
    logic                w_head_wb;
    logic [4:0]          w_head_rd;

    assign w_wr_idx  = r_wr_ptr[c_ADDR_W-1:0];
    assign w_rd_idx  = r_rd_ptr[c_ADDR_W-1:0];
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) && (w_wr_idx == w_rd_idx);
    assign w_push    = core_valid_i && !w_full;
    assign w_pop     = (r_state == ST_ISSUE) && !w_empty;
    assign w_head_wb = r_mem_wb[w_rd_idx];
    assign w_head_rd = r_mem_rd[w_rd_idx];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_instr[w_wr_idx] <= core_instr_i;
            r_mem_rs1[w_wr_idx]   <= core_rs1_i;
            r_mem_rs2[w_wr_idx]   <= core_rs2_i;
            r_mem_rd[w_wr_idx]    <= core_rd_i;
            r_mem_wb[w_wr_idx]    <= core_wb_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= ST_ISSUE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_rd      <= '0;
            r_rsp_illegal <= 1'b0;
            r_illegal_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            case (r_state)
                ST_ISSUE: begin
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                        if (acc_illegal_i && (r_illegal_cnt != '1)) begin
                            r_illegal_cnt <= r_illegal_cnt + c_CNT_ONE;
                        end
                        // Only illegal or writeback instructions owe the core a response.
                        if (acc_illegal_i || w_head_wb) begin
                            r_state       <= ST_RESP;
                            r_rsp_valid   <= 1'b1;
                            r_rsp_data    <= acc_illegal_i ? 32'h0 : acc_rd_i;
                            r_rsp_rd      <= w_head_rd;
                            r_rsp_illegal <= acc_illegal_i;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        r_state     <= ST_ISSUE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_ISSUE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign core_ready_o  = !w_full;
    assign acc_valid_o   = w_pop;
    assign acc_instr_o   = r_mem_instr[w_rd_idx];
    assign acc_rs1_o     = r_mem_rs1[w_rd_idx];
    assign acc_rs2_o     = r_mem_rs2[w_rd_idx];
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_data_o    = r_rsp_data;
    assign rsp_rd_o      = r_rsp_rd;
    assign rsp_illegal_o = r_rsp_illegal;
    assign busy_o        = !w_empty || (r_state == ST_RESP);
    assign illegal_cnt_o = r_illegal_cnt;

endmodule
`default_nettype wire

// File: tb/tb_spatz_offload_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spatz_offload_ctrl
// Description : Directed self-checking bench for spatz_offload_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spatz_offload_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_valid_i;
    logic        core_ready_o;
    logic [31:0] core_instr_i;
    logic [31:0] core_rs1_i;
    logic [31:0] core_rs2_i;
    logic [4:0]  core_rd_i;
    logic        core_wb_i;
    logic        acc_valid_o;
    logic [31:0] acc_instr_o;
    logic [31:0] acc_rs1_o;
    logic [31:0] acc_rs2_o;
    logic        acc_illegal_i;
    logic [31:0] acc_rd_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic [4:0]  rsp_rd_o;
    logic        rsp_illegal_o;
    logic        busy_o;
    logic [15:0] illegal_cnt_o;

    int n_cmp = 0;
    int n_mis = 0;

    spatz_offload_ctrl #(
        .FifoDepth (2),
        .StatWidth (16)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .core_valid_i  (core_valid_i),
        .core_ready_o  (core_ready_o),
        .core_instr_i  (core_instr_i),
        .core_rs1_i    (core_rs1_i),
        .core_rs2_i    (core_rs2_i),
        .core_rd_i     (core_rd_i),
        .core_wb_i     (core_wb_i),
        .acc_valid_o   (acc_valid_o),
        .acc_instr_o   (acc_instr_o),
        .acc_rs1_o     (acc_rs1_o),
        .acc_rs2_o     (acc_rs2_o),
        .acc_illegal_i (acc_illegal_i),
        .acc_rd_i      (acc_rd_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .rsp_rd_o      (rsp_rd_o),
        .rsp_illegal_o (rsp_illegal_o),
        .busy_o        (busy_o),
        .illegal_cnt_o (illegal_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] instr, input logic [4:0] rd, input logic wb);
        core_valid_i = 1'b1;
        core_instr_i = instr;
        core_rs1_i   = instr ^ 32'h1111_1111;
        core_rs2_i   = instr ^ 32'h2222_2222;
        core_rd_i    = rd;
        core_wb_i    = wb;
    endtask

    initial begin
        logic [31:0] seq [4];
        seq[0] = 32'h0010_0057;
        seq[1] = 32'h0020_0057;
        seq[2] = 32'h0030_0057;
        seq[3] = 32'h0040_0057;

        rst_ni        = 1'b0;
        core_valid_i  = 1'b0;
        core_instr_i  = '0;
        core_rs1_i    = '0;
        core_rs2_i    = '0;
        core_rd_i     = '0;
        core_wb_i     = 1'b0;
        acc_illegal_i = 1'b0;
        acc_rd_i      = '0;
        rsp_ready_i   = 1'b0;

        // Reset values
        step();
        step();
        check_val("rst_acc_valid", acc_valid_o, 0);
        check_val("rst_rsp_valid", rsp_valid_o, 0);
        check_val("rst_rsp_data", rsp_data_o, 0);
        check_val("rst_rsp_rd", rsp_rd_o, 0);
        check_val("rst_rsp_illegal", rsp_illegal_o, 0);
        check_val("rst_busy", busy_o, 0);
        check_val("rst_core_ready", core_ready_o, 1);
        check_val("rst_illegal_cnt", illegal_cnt_o, 0);
        rst_ni = 1'b1;
        step();

        // Single legal non-writeback request
        drive_req(32'h0000_0057, 5'd0, 1'b0);
        #1;
        check_val("nwb_ready", core_ready_o, 1);
        check_val("nwb_acc_valid_pre", acc_valid_o, 0);
        step();
        core_valid_i = 1'b0;
        #1;
        check_val("nwb_acc_valid", acc_valid_o, 1);
        check_val("nwb_acc_instr", acc_instr_o, 32'h0000_0057);
        check_val("nwb_acc_rs1", acc_rs1_o, 32'h1111_1146);
        check_val("nwb_acc_rs2", acc_rs2_o, 32'h2222_2275);
        step();
        #1;
        check_val("nwb_acc_valid_post", acc_valid_o, 0);
        check_val("nwb_rsp_valid", rsp_valid_o, 0);
        check_val("nwb_busy_post", busy_o, 0);

        // Writeback request with stalled response
        drive_req(32'h0000_1057, 5'd5, 1'b1);
        step();
        core_valid_i = 1'b0;
        acc_rd_i     = 32'h0000_0080;
        #1;
        check_val("wb_acc_valid", acc_valid_o, 1);
        step();
        acc_rd_i = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) rsp_ready_i = 1'b1;
            #1;
            check_val("wb_rsp_valid", rsp_valid_o, 1);
            check_val("wb_rsp_data", rsp_data_o, 32'h80);
            check_val("wb_rsp_rd", rsp_rd_o, 5);
            check_val("wb_rsp_illegal", rsp_illegal_o, 0);
            check_val("wb_acc_valid_resp", acc_valid_o, 0);
            check_val("wb_busy_resp", busy_o, 1);
            step();
        end
        rsp_ready_i = 1'b0;
        #1;
        check_val("wb_rsp_valid_done", rsp_valid_o, 0);
        check_val("wb_busy_done", busy_o, 0);

        // Illegal instruction
        drive_req(32'h0000_0000, 5'd7, 1'b0);
        step();
        core_valid_i  = 1'b0;
        acc_illegal_i = 1'b1;
        acc_rd_i      = 32'h0000_DEAD;
        #1;
        check_val("ill_acc_valid", acc_valid_o, 1);
        check_val("ill_cnt_before", illegal_cnt_o, 0);
        step();
        acc_illegal_i = 1'b0;
        acc_rd_i      = 32'h0;
        #1;
        check_val("ill_rsp_valid", rsp_valid_o, 1);
        check_val("ill_rsp_illegal", rsp_illegal_o, 1);
        check_val("ill_rsp_data", rsp_data_o, 0);
        check_val("ill_rsp_rd", rsp_rd_o, 7);
        check_val("ill_cnt_after", illegal_cnt_o, 1);
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        #1;
        check_val("ill_rsp_valid_done", rsp_valid_o, 0);

        // Backpressure: FIFO fills while a response is stalled
        drive_req(32'h0000_A057, 5'd1, 1'b1);
        #1;
        check_val("bp_ready0", core_ready_o, 1);
        step();
        drive_req(32'h0000_B057, 5'd2, 1'b0);
        acc_rd_i = 32'h11;
        #1;
        check_val("bp_acc_valid_a", acc_valid_o, 1);
        check_val("bp_acc_instr_a", acc_instr_o, 32'h0000_A057);
        check_val("bp_ready1", core_ready_o, 1);
        step();
        drive_req(32'h0000_C057, 5'd3, 1'b0);
        acc_rd_i = 32'h0;
        #1;
        check_val("bp_rsp_valid", rsp_valid_o, 1);
        check_val("bp_ready2", core_ready_o, 1);
        step();
        drive_req(32'h0000_D057, 5'd4, 1'b0);
        #1;
        check_val("bp_ready_full", core_ready_o, 0);
        check_val("bp_rsp_data", rsp_data_o, 32'h11);
        check_val("bp_rsp_rd", rsp_rd_o, 1);
        step();
        rsp_ready_i = 1'b1;
        #1;
        check_val("bp_ready_full2", core_ready_o, 0);
        step();
        core_valid_i = 1'b0;
        rsp_ready_i  = 1'b0;
        #1;
        check_val("bp_rsp_valid_done", rsp_valid_o, 0);
        check_val("bp_acc_valid_b", acc_valid_o, 1);
        check_val("bp_acc_instr_b", acc_instr_o, 32'h0000_B057);
        step();
        check_val("bp_acc_valid_c", acc_valid_o, 1);
        check_val("bp_acc_instr_c", acc_instr_o, 32'h0000_C057);
        step();
        check_val("bp_acc_valid_end", acc_valid_o, 0);
        check_val("bp_busy_end", busy_o, 0);

        // Four back-to-back non-writeback requests, pointers wrap twice
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive_req(seq[i], 5'd0, 1'b0);
            else core_valid_i = 1'b0;
            #1;
            if (i == 0) begin
                check_val("b2b_acc_valid_0", acc_valid_o, 0);
            end else begin
                check_val("b2b_acc_valid", acc_valid_o, 1);
                check_val("b2b_acc_instr", acc_instr_o, seq[i-1]);
            end
            check_val("b2b_rsp_valid", rsp_valid_o, 0);
            step();
        end
        #1;
        check_val("b2b_acc_valid_end", acc_valid_o, 0);
        check_val("b2b_busy_end", busy_o, 0);

        // Reset during a response with two entries queued
        drive_req(32'h0000_E057, 5'd3, 1'b1);
        step();
        drive_req(32'h0000_F057, 5'd0, 1'b0);
        acc_rd_i = 32'h33;
        #1;
        check_val("rr_acc_valid", acc_valid_o, 1);
        step();
        drive_req(32'h0001_0057, 5'd0, 1'b0);
        acc_rd_i = 32'h0;
        step();
        core_valid_i = 1'b0;
        #1;
        check_val("rr_rsp_valid_pre", rsp_valid_o, 1);
        check_val("rr_ready_full", core_ready_o, 0);
        check_val("rr_busy_pre", busy_o, 1);
        #1;
        rst_ni = 1'b0;
        #1;
        check_val("rr_rsp_valid", rsp_valid_o, 0);
        check_val("rr_busy", busy_o, 0);
        check_val("rr_acc_valid_rst", acc_valid_o, 0);
        check_val("rr_ready_rst", core_ready_o, 1);
        check_val("rr_rsp_data", rsp_data_o, 0);
        check_val("rr_rsp_rd", rsp_rd_o, 0);
        check_val("rr_cnt", illegal_cnt_o, 0);
        step();
        step();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("rr_acc_valid_post", acc_valid_o, 0);
            check_val("rr_busy_post", busy_o, 0);
            check_val("rr_rsp_valid_post", rsp_valid_o, 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
